// File: rtl/note_render_pkg.sv
// Shared types and constants for the note sprite renderer.
package note_render_pkg;

  localparam int unsigned COORD_W          = 10;
  localparam int unsigned ADDR_W           = 10;
  localparam int unsigned SPR_W_DEFAULT    = 20;
  localparam int unsigned SPR_H_DEFAULT    = 30;
  localparam int unsigned V_ACTIVE_DEFAULT = 480;

  // One note slot: glyph top-left corner and visibility.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               show;
  } note_slot_t;

endpackage

// File: rtl/note_hit_test.sv
// Combinational bounding-box test of one raster coordinate against one note slot.
module note_hit_test
  import note_render_pkg::*;
#(
  parameter int unsigned SPR_W = SPR_W_DEFAULT,
  parameter int unsigned SPR_H = SPR_H_DEFAULT,
  parameter int unsigned DX_W  = $clog2(SPR_W),
  parameter int unsigned DY_W  = $clog2(SPR_H)
) (
  input  logic [COORD_W-1:0] hcount,
  input  logic [COORD_W-1:0] vcount,
  input  note_slot_t         slot,
  output logic               hit,
  output logic [DX_W-1:0]    dx,
  output logic [DY_W-1:0]    dy
);

  localparam int unsigned OFF_W = COORD_W + 1;

  logic signed [OFF_W-1:0] off_x;
  logic signed [OFF_W-1:0] off_y;
  logic                    in_x;
  logic                    in_y;

  // One extra sign bit so a pixel left of / above the glyph never aliases into range.
  assign off_x = $signed({1'b0, hcount}) - $signed({1'b0, slot.x});
  assign off_y = $signed({1'b0, vcount}) - $signed({1'b0, slot.y});

  assign in_x = !off_x[OFF_W-1] && (off_x < $signed(OFF_W'(SPR_W)));
  assign in_y = !off_y[OFF_W-1] && (off_y < $signed(OFF_W'(SPR_H)));

  assign hit = slot.show && in_x && in_y;
  assign dx  = off_x[DX_W-1:0];
  assign dy  = off_y[DY_W-1:0];

endmodule

// File: rtl/note_sprite_renderer.sv
// Note sprite renderer: double-buffered note table, per-slot hit test, priority
// select, glyph ROM addressing and a 3-stage delay-aligned pixel/sync pipeline.
// Optional build macro NOTE_BBOX_DEBUG_EN also lights the bounding-box border.
module note_sprite_renderer
  import note_render_pkg::*;
#(
  parameter int unsigned NUM_NOTES = 8,
  parameter int unsigned SPR_W     = SPR_W_DEFAULT,
  parameter int unsigned SPR_H     = SPR_H_DEFAULT,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [COORD_W-1:0]           hcount,
  input  logic [COORD_W-1:0]           vcount,
  input  logic                         de,
  input  logic                         hsync_n,
  input  logic                         vsync_n,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(NUM_NOTES)-1:0] wr_idx,
  input  logic [COORD_W-1:0]           wr_x,
  input  logic [COORD_W-1:0]           wr_y,
  input  logic                         wr_show,
  output logic [ADDR_W-1:0]            rom_addr,
  input  logic                         rom_pixel,
  output logic                         pixel_on,
  output logic                         de_out,
  output logic                         hsync_n_out,
  output logic                         vsync_n_out
);

  localparam int unsigned DX_W = $clog2(SPR_W);
  localparam int unsigned DY_W = $clog2(SPR_H);

  note_slot_t        shadow_q [NUM_NOTES];
  note_slot_t        active_q [NUM_NOTES];

  logic              commit_c;
  logic [NUM_NOTES-1:0] hit_a;
  logic [DX_W-1:0]   dx_a [NUM_NOTES];
  logic [DY_W-1:0]   dy_a [NUM_NOTES];

  logic              sel_hit;
  logic [DX_W-1:0]   sel_dx;
  logic [DY_W-1:0]   sel_dy;
  logic [ADDR_W-1:0] addr_c;
  logic              live_c;

  logic              hit_d1, de_d1, hs_d1, vs_d1;
  logic              hit_d2, de_d2, hs_d2, vs_d2;
`ifdef NOTE_BBOX_DEBUG_EN
  logic              border_c;
  logic              border_d1, border_d2;
`endif

  // Commit happens on the first pixel of the first blanking line; writes stall there.
  assign commit_c = (vcount == COORD_W'(V_ACTIVE)) && (hcount == '0);
  assign wr_ready = ~commit_c;

  // Shadow table takes writes; active table snapshots it at the commit point.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NUM_NOTES); i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else if (commit_c) begin
      active_q <= shadow_q;
    end else if (wr_valid && wr_ready) begin
      shadow_q[wr_idx] <= '{x: wr_x, y: wr_y, show: wr_show};
    end
  end

  // One box checker per slot against the active table.
  for (genvar g = 0; g < int'(NUM_NOTES); g++) begin : g_hit
    note_hit_test #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .DX_W  (DX_W),
      .DY_W  (DY_W)
    ) u_hit (
      .hcount (hcount),
      .vcount (vcount),
      .slot   (active_q[g]),
      .hit    (hit_a[g]),
      .dx     (dx_a[g]),
      .dy     (dy_a[g])
    );
  end

  // Priority select: scanning downward so the lowest-indexed hit is written last.
  always_comb begin
    sel_hit = 1'b0;
    sel_dx  = '0;
    sel_dy  = '0;
    for (int i = int'(NUM_NOTES) - 1; i >= 0; i--) begin
      if (hit_a[i]) begin
        sel_hit = 1'b1;
        sel_dx  = dx_a[i];
        sel_dy  = dy_a[i];
      end
    end
  end

  // Glyph address dy*SPR_W + dx; 20-wide glyphs use the 16+4 shift-add form.
  if (SPR_W == 20) begin : g_addr_shift
    assign addr_c = (ADDR_W'(sel_dy) << 4) + (ADDR_W'(sel_dy) << 2) + ADDR_W'(sel_dx);
  end else begin : g_addr_mul
    assign addr_c = ADDR_W'(sel_dy * SPR_W) + ADDR_W'(sel_dx);
  end

  assign live_c = de && sel_hit;

`ifdef NOTE_BBOX_DEBUG_EN
  assign border_c = (sel_dx == '0) || (sel_dx == DX_W'(SPR_W - 1)) ||
                    (sel_dy == '0) || (sel_dy == DY_W'(SPR_H - 1));
`endif

  // Stage 1: register ROM address, hit flag and raster controls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr  <= '0;
      hit_d1    <= 1'b0;
      de_d1     <= 1'b0;
      hs_d1     <= 1'b1;
      vs_d1     <= 1'b1;
`ifdef NOTE_BBOX_DEBUG_EN
      border_d1 <= 1'b0;
`endif
    end else begin
      rom_addr  <= live_c ? addr_c : '0;
      hit_d1    <= live_c;
      de_d1     <= de;
      hs_d1     <= hsync_n;
      vs_d1     <= vsync_n;
`ifdef NOTE_BBOX_DEBUG_EN
      border_d1 <= live_c && border_c;
`endif
    end
  end

  // Stage 2: track the ROM's own register delay.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_d2    <= 1'b0;
      de_d2     <= 1'b0;
      hs_d2     <= 1'b1;
      vs_d2     <= 1'b1;
`ifdef NOTE_BBOX_DEBUG_EN
      border_d2 <= 1'b0;
`endif
    end else begin
      hit_d2    <= hit_d1;
      de_d2     <= de_d1;
      hs_d2     <= hs_d1;
      vs_d2     <= vs_d1;
`ifdef NOTE_BBOX_DEBUG_EN
      border_d2 <= border_d1;
`endif
    end
  end

  // Stage 3: merge the ROM bit and register the aligned output stream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pixel_on    <= 1'b0;
      de_out      <= 1'b0;
      hsync_n_out <= 1'b1;
      vsync_n_out <= 1'b1;
    end else begin
`ifdef NOTE_BBOX_DEBUG_EN
      pixel_on    <= hit_d2 & (rom_pixel | border_d2);
`else
      pixel_on    <= hit_d2 & rom_pixel;
`endif
      de_out      <= de_d2;
      hsync_n_out <= hs_d2;
      vsync_n_out <= vs_d2;
    end
  end

endmodule

// File: tb/tb_note_sprite_renderer.sv
// Self-checking bench for note_sprite_renderer with a behavioural note/ROM model.
`timescale 1ns/1ps
module tb_note_sprite_renderer;

  localparam int NN = 8;
`ifdef NOTE_BBOX_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [9:0] hcount, vcount;
  logic       de, hsync_n, vsync_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [2:0] wr_idx;
  logic [9:0] wr_x, wr_y;
  logic       wr_show;
  logic [9:0] rom_addr;
  logic       rom_pixel = 1'b0;
  logic       pixel_on, de_out, hsync_n_out, vsync_n_out;

  always #5 clk = ~clk;

  note_sprite_renderer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .hcount      (hcount),
    .vcount      (vcount),
    .de          (de),
    .hsync_n     (hsync_n),
    .vsync_n     (vsync_n),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_idx      (wr_idx),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_show     (wr_show),
    .rom_addr    (rom_addr),
    .rom_pixel   (rom_pixel),
    .pixel_on    (pixel_on),
    .de_out      (de_out),
    .hsync_n_out (hsync_n_out),
    .vsync_n_out (vsync_n_out)
  );

  // Glyph ROM model: random bitmap, one-clock registered read.
  bit glyph [600];
  always @(posedge clk) rom_pixel <= (int'(rom_addr) < 600) ? glyph[int'(rom_addr)] : 1'b0;

  typedef struct { int x; int y; bit show; } note_t;
  typedef struct { bit pix; bit de; bit hs; bit vs; } exp_t;

  note_t shadow_m [NN];
  note_t active_m [NN];
  exp_t  q [$];
  int    checks   = 0;
  int    failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: first visible slot whose box contains (h,v) wins.
  function automatic void ref_pixel(input int h, input int v, input bit den,
                                    output bit hit, output int addr, output bit border);
    hit = 1'b0; addr = 0; border = 1'b0;
    if (!den) return;
    for (int i = 0; i < NN; i++) begin
      int ox, oy;
      ox = h - active_m[i].x;
      oy = v - active_m[i].y;
      if (active_m[i].show && ox >= 0 && ox < 20 && oy >= 0 && oy < 30) begin
        hit = 1'b1;
        addr = oy * 20 + ox;
        border = (ox == 0) || (ox == 19) || (oy == 0) || (oy == 29);
        return;
      end
    end
  endfunction

  task automatic model_clear();
    exp_t idle;
    idle = '{pix: 1'b0, de: 1'b0, hs: 1'b1, vs: 1'b1};
    for (int i = 0; i < NN; i++) begin
      shadow_m[i] = '{x: 0, y: 0, show: 1'b0};
      active_m[i] = '{x: 0, y: 0, show: 1'b0};
    end
    q.delete();
    q.push_back(idle);
    q.push_back(idle);
  endtask

  // One pixel clock: drive, check ready, model the edge, check stage-1 and stage-3 outputs.
  task automatic cycle(input int h, input int v, input bit den, input bit hs, input bit vs,
                       input bit wv, input int widx, input int wx, input int wy, input bit wshow);
    bit hit, brd, commit;
    int addr;
    exp_t e;
    hcount = 10'(h); vcount = 10'(v); de = den; hsync_n = hs; vsync_n = vs;
    wr_valid = wv; wr_idx = 3'(widx); wr_x = 10'(wx); wr_y = 10'(wy); wr_show = wshow;
    #1;
    commit = (v == 480) && (h == 0);
    chk("wr_ready", 32'(wr_ready), 32'(!commit));
    ref_pixel(h, v, den, hit, addr, brd);
    if (commit) active_m = shadow_m;
    else if (wv) shadow_m[widx] = '{x: wx, y: wy, show: wshow};
    @(posedge clk);
    #1;
    chk("rom_addr", 32'(rom_addr), 32'(addr));
    e.pix = hit && (glyph[addr] || (DBG && brd));
    e.de = den; e.hs = hs; e.vs = vs;
    q.push_back(e);
    e = q.pop_front();
    chk("pixel_on", 32'(pixel_on), 32'(e.pix));
    chk("de_out", 32'(de_out), 32'(e.de));
    chk("hsync_n_out", 32'(hsync_n_out), 32'(e.hs));
    chk("vsync_n_out", 32'(vsync_n_out), 32'(e.vs));
  endtask

  task automatic px(input int h, input int v);
    cycle(h, v, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic rnd_px(input int h, input int v);
    cycle(h, v, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic wr(input int idx, input int x, input int y, input bit s);
    cycle(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'b0, 1'b1, 1'b1,
          1'b1, idx, x, y, s);
  endtask

  task automatic commit_frame();
    cycle(0, 480, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Pixel near slot j's box (including just outside it), clamped onto the screen.
  task automatic near_px(input int j);
    int h, v;
    h = active_m[j].x + int'($urandom_range(0, 25)) - 3;
    v = active_m[j].y + int'($urandom_range(0, 35)) - 3;
    if (h < 0 || h > 639) h = int'($urandom_range(0, 639));
    if (v < 0 || v > 479) v = int'($urandom_range(0, 479));
    rnd_px(h, v);
  endtask

  initial begin
    for (int i = 0; i < 600; i++) glyph[i] = 1'($urandom_range(0, 1));
    glyph[205] = 1'b1; glyph[310] = 1'b1; glyph[109] = 1'b1;

    reset_n = 1'b0; hcount = '0; vcount = '0; de = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1;
    wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0; wr_show = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_pixel_on", 32'(pixel_on), 32'd0);
    chk("reset_de_out", 32'(de_out), 32'd0);
    chk("reset_hsync", 32'(hsync_n_out), 32'd1);
    chk("reset_vsync", 32'(vsync_n_out), 32'd1);
    chk("reset_wr_ready", 32'(wr_ready), 32'd1);
    reset_n = 1'b1;

    // Empty tables: nothing drawn, syncs delayed by three clocks.
    for (int i = 0; i < 300; i++) rnd_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 524)));
    commit_frame();
    for (int i = 0; i < 50; i++) rnd_px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));

    // Single note at (100,50).
    wr(0, 100, 50, 1'b1);
    px(105, 60);
    chk("uncommitted_addr", 32'(rom_addr), 32'd0);
    commit_frame();
    px(105, 60);
    chk("addr_205", 32'(rom_addr), 32'd205);
    px(0, 0);
    px(0, 0);
    chk("pixel_205", 32'(pixel_on), 32'd1);

    // Overlapping slots 0 and 3; then hide slot 0.
    wr(0, 200, 200, 1'b1);
    wr(3, 200, 200, 1'b1);
    commit_frame();
    px(210, 215);
    chk("addr_310_slot0", 32'(rom_addr), 32'd310);
    wr(0, 200, 200, 1'b0);
    commit_frame();
    px(210, 215);
    chk("addr_310_slot3", 32'(rom_addr), 32'd310);

    // Write held across the commit cycle, lands after it, shows one frame later.
    cycle(0, 480, 1'b0, 1'b1, 1'b0, 1'b1, 5, 300, 300, 1'b1);
    cycle(1, 480, 1'b0, 1'b1, 1'b0, 1'b1, 5, 300, 300, 1'b1);
    px(305, 305);
    chk("pending_write_hidden", 32'(rom_addr), 32'd0);
    commit_frame();
    px(305, 305);
    chk("addr_105_after_commit", 32'(rom_addr), 32'd105);

    // Right-edge clipping at x=630.
    wr(6, 630, 100, 1'b1);
    commit_frame();
    px(639, 105);
    chk("addr_edge_109", 32'(rom_addr), 32'd109);
    px(0, 105);
    chk("edge_no_wrap", 32'(rom_addr), 32'd0);
    px(0, 0);
    px(0, 0);

    // Randomised note tables with pixels clustered around the boxes.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 4; k++)
        wr(int'($urandom_range(0, 7)), int'($urandom_range(0, 639)), int'($urandom_range(0, 479)),
           ($urandom_range(0, 9) != 0));
      commit_frame();
      for (int i = 0; i < 150; i++) near_px(int'($urandom_range(0, 7)));
    end

    // Reset mid-line with notes active.
    for (int i = 0; i < 5; i++) near_px(int'($urandom_range(0, 7)));
    reset_n = 1'b0;
    #1;
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_pixel_on", 32'(pixel_on), 32'd0);
    chk("midrst_de_out", 32'(de_out), 32'd0);
    chk("midrst_hsync", 32'(hsync_n_out), 32'd1);
    chk("midrst_vsync", 32'(vsync_n_out), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_clear();
    for (int i = 0; i < 40; i++) px(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    px(105, 60);
    px(210, 215);
    commit_frame();
    px(210, 215);
    chk("post_reset_blank", 32'(rom_addr), 32'd0);
    wr(2, 100, 50, 1'b1);
    commit_frame();
    px(105, 60);
    chk("post_reset_redraw", 32'(rom_addr), 32'd205);
    for (int i = 0; i < 60; i++) near_px(2);
    px(0, 0);
    px(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sprite_renderer.md
# note_sprite_renderer

Pixel-pipeline stage sitting directly upstream of the 20x30 quarter-note glyph ROM. It holds a double-buffered table of note positions and compares each incoming VGA raster coordinate against every note's bounding box. It drives the ROM address for the highest-priority hit and merges the ROM's registered pixel bit into a delay-aligned `pixel_on` / sync stream for the colour mixer.

## Interface
- `NUM_NOTES`, 8, number of note slots (index width `$clog2(NUM_NOTES)`)
- `SPR_W`, 20, glyph width in pixels
- `SPR_H`, 30, glyph height in pixels
- `V_ACTIVE`, 480, first non-visible line; the table commit happens on this line
- `clk` input 1: pixel clock; the only clock
- `reset_n` input 1: asynchronous, active-low reset
- `hcount` input 10: raster column
- `vcount` input 10: raster line
- `de` input 1: display enable
- `hsync_n` input 1: horizontal sync, active low
- `vsync_n` input 1: vertical sync, active low
- `wr_valid` input 1: note-write request
- `wr_ready` output 1: write accepted when high together with `wr_valid`
- `wr_idx` input 3: slot index
- `wr_x` input 10: glyph top-left column
- `wr_y` input 10: glyph top-left row
- `wr_show` input 1: slot visible
- `rom_addr` output 10: glyph ROM address, `dy*SPR_W + dx`
- `rom_pixel` input 1: ROM data, registered by the ROM one clock after `rom_addr`
- `pixel_on` output 1: note pixel lit
- `de_out` output 1: delayed `de`
- `hsync_n_out` output 1: delayed `hsync_n`
- `vsync_n_out` output 1: delayed `vsync_n`

## Operation
- **Shadow table.**
  - Written by accepted writes (`wr_valid && wr_ready`).
  - Each write stores {x, y, show} into slot `wr_idx`.
  - A later write to the same slot overwrites it.
- **Active table.**
  - Read only by the renderer.
  - Copied from the shadow table in the commit cycle.
  - The commit cycle is the cycle in which the input `vcount == V_ACTIVE && hcount == 0`.
  - In the commit cycle `wr_ready` is 0; otherwise it is 1. A write can therefore never collide with a commit.
- **Hit test per slot i.**
  - A pixel hits slot i when `show_i` is set, `hcount - x_i` lies in [0, SPR_W-1], and `vcount - y_i` lies in [0, SPR_H-1].
  - The subtraction uses 11-bit signed arithmetic so negative offsets never alias.
  - A note at `x = 630` is clipped at the screen edge and does not wrap to column 0.
- **Priority.** The lowest-indexed hitting slot wins.
- **Address.**
  - Computed as `dy*20 + dx` using shift-add, `(dy<<4) + (dy<<2) + dx`.
  - Range is 0..599.
- **No hit or de low.** `rom_addr` is forced to 0 and the internal hit flag is cleared.
- **Reset mid-frame.** Both tables are cleared to show=0 and the pipeline flushes. Output is blank until new writes are made and committed.

## Timing
- Stage 1: the hit test and address are computed from the inputs and registered into `rom_addr`, the hit flag and the sync/de delay.
- Stage 2: the ROM registers `rom_pixel`; the hit flag and syncs are delayed alongside it.
- Stage 3: `pixel_on <= hit_d2 & rom_pixel`; syncs and `de` are registered out.
- Latency: inputs at cycle N appear at `pixel_on` / `*_out` after the cycle N+3 edge. `rom_addr` is valid after the N+1 edge.
- Reset values:
  - `rom_addr` = 0, `pixel_on` = 0, `de_out` = 0
  - `hsync_n_out` = 1, `vsync_n_out` = 1
  - `wr_ready` = 1, internal delay registers idle
- A write accepted at cycle W reaches the screen only after the next commit.

## Configuration
- `NOTE_BBOX_DEBUG_EN` defined:
  - Stage 3 also asserts `pixel_on` on the one-pixel border of every hit bounding box (dx ∈ {0, SPR_W-1} or dy ∈ {0, SPR_H-1}), regardless of `rom_pixel`.
  - The border flag is pipelined with the hit flag.
- Undefined: no border logic exists and `pixel_on` is strictly `hit & rom_pixel`.

## Structure
- Shared package `note_render_pkg` holds:
  - `note_slot_t` struct {x[9:0], y[9:0], show}
  - `SPR_W`, `SPR_H` and `V_ACTIVE` defaults
  - the `ADDR_W = 10` constant
- One sub-module, `note_hit_test`: combinational per-slot box check producing {hit, dx, dy}, instantiated `NUM_NOTES` times by generate.
- Top level contains the tables, commit logic, priority encoder, address arithmetic and delay pipeline.

## Test plan
- Release `reset_n`, drive a full raster with no writes -> `pixel_on` stays 0 and `rom_addr` stays 0. `*_out` match the inputs delayed 3 clocks.
- Write slot 0 at (100,50), show=1, then commit. At `hcount=105, vcount=60` expect `rom_addr = 10*20+5 = 205` after 1 clock. With `rom_pixel=1`, expect `pixel_on=1` 3 clocks after the input.
- Slots 0 and 3 both at (200,200): at (210,215) the address comes from slot 0. Hide slot 0 and commit -> the same pixel is still addressed via slot 3, giving `rom_addr = 15*20+10 = 310`.
- Put `wr_valid` high across the commit cycle -> `wr_ready=0` in that cycle only. The write lands the cycle after and displays one frame later.
- Slot at x=630: at `hcount=639` expect `dx=9` (`rom_addr = dy*20 + 9`). At `hcount=0` on the same line expect no hit.
- Assert `reset_n` low mid-line with notes active -> outputs immediately return to their reset values. After release, no note is drawn before a new write and commit.
